// File: rtl/next_pc_unit.sv
// next_pc_unit: program counter and next-PC selection for a word-addressed
// single-cycle MIPS datapath, with a RUN/STALL/HALT controller, JAL link value
// and a retired-instruction counter.
module next_pc_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        halt,
  input  logic        branch_taken,
  input  logic [15:0] branch_offset,
  input  logic        jump,
  input  logic [31:0] jump_target,
  input  logic        jump_reg,
  input  logic [31:0] reg_target,
  output logic [31:0] pc,
  output logic [31:0] pc_plus1,
  output logic [31:0] link_addr,
  output logic        fetch_valid,
  output logic        halted,
  output logic [31:0] retired_count
);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_STALL = 2'd1,
    ST_HALT  = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] count_q, count_d;
  logic [31:0] seq_pc;
  logic [31:0] branch_pc;

  assign seq_pc    = pc_q + 32'd1;
  assign branch_pc = seq_pc + {{16{branch_offset[15]}}, branch_offset};

  // Next state, next PC and retire count; reset is applied in the register block.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    count_d = count_q;
    if (state_q == ST_HALT) begin
      state_d = ST_HALT;
    end else if (halt && state_q == ST_RUN) begin
      state_d = ST_HALT;
    end else if (stall) begin
      state_d = ST_STALL;
    end else begin
      state_d = ST_RUN;
      // Leaving STALL only re-enters RUN; the held instruction (and its
      // control inputs) is executed on the following edge.
      if (state_q == ST_RUN) begin
        count_d = count_q + 32'd1;
        if (jump_reg) begin
          pc_d = reg_target;
        end else if (jump) begin
          pc_d = jump_target;
        end else if (branch_taken) begin
          pc_d = branch_pc;
        end else begin
          pc_d = seq_pc;
        end
      end
    end
  end

  // State, PC and counter registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_RUN;
      pc_q    <= RESET_PC;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      count_q <= count_d;
    end
  end

  assign pc            = pc_q;
  assign pc_plus1      = seq_pc;
  assign link_addr     = seq_pc;
  assign fetch_valid   = (state_q == ST_RUN);
  assign halted        = (state_q == ST_HALT);
  assign retired_count = count_q;

endmodule

// File: tb/tb_next_pc_unit.sv
// tb_next_pc_unit: scoreboard bench for next_pc_unit; a driver issues directed
// and random control cycles and queues the expected post-edge state, a monitor
// compares the DUT after every rising edge.
module tb_next_pc_unit;

  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam int M_RUN   = 0;
  localparam int M_STALL = 1;
  localparam int M_HALT  = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b0, stall = 1'b0, halt = 1'b0, branch_taken = 1'b0;
  logic [15:0] branch_offset = '0;
  logic        jump = 1'b0, jump_reg = 1'b0;
  logic [31:0] jump_target = '0, reg_target = '0;
  logic [31:0] pc, pc_plus1, link_addr, retired_count;
  logic        fetch_valid, halted;

  next_pc_unit #(.RESET_PC(RST_PC)) dut (
    .clk(clk), .reset(reset), .stall(stall), .halt(halt),
    .branch_taken(branch_taken), .branch_offset(branch_offset),
    .jump(jump), .jump_target(jump_target),
    .jump_reg(jump_reg), .reg_target(reg_target),
    .pc(pc), .pc_plus1(pc_plus1), .link_addr(link_addr),
    .fetch_valid(fetch_valid), .halted(halted), .retired_count(retired_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic        fv;
    logic        hl;
    logic [31:0] cnt;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model state
  logic [31:0] m_pc  = RST_PC;
  logic [31:0] m_cnt = '0;
  int          m_mode = M_RUN;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: after every rising edge, compare against the oldest queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check32("pc", pc, e.pc);
        check32("pc_plus1", pc_plus1, e.pc + 32'd1);
        check32("link_addr", link_addr, e.pc + 32'd1);
        check32("fetch_valid", {31'd0, fetch_valid}, {31'd0, e.fv});
        check32("halted", {31'd0, halted}, {31'd0, e.hl});
        check32("retired_count", retired_count, e.cnt);
      end
    end
  end

  // Drive one cycle of inputs and queue the state expected after the next edge.
  task automatic step(input logic r, input logic s, input logic h, input logic bt,
                      input logic [15:0] off, input logic j, input logic [31:0] jt,
                      input logic jr, input logic [31:0] rt);
    exp_t e;
    logic [31:0] off32;
    @(negedge clk);
    reset = r; stall = s; halt = h; branch_taken = bt; branch_offset = off;
    jump = j; jump_target = jt; jump_reg = jr; reg_target = rt;
    off32 = 32'(signed'(off));
    if (r) begin
      m_pc = RST_PC; m_mode = M_RUN; m_cnt = 0;
    end else if (m_mode == M_HALT) begin
      m_mode = M_HALT;
    end else if (m_mode == M_RUN && h) begin
      m_mode = M_HALT;
    end else if (s) begin
      m_mode = M_STALL;
    end else begin
      if (m_mode == M_RUN) begin
        if (jr)      m_pc = rt;
        else if (j)  m_pc = jt;
        else if (bt) m_pc = m_pc + 1 + off32;
        else         m_pc = m_pc + 1;
        m_cnt = m_cnt + 1;
      end
      m_mode = M_RUN;
    end
    e.pc  = m_pc;
    e.fv  = (m_mode == M_RUN);
    e.hl  = (m_mode == M_HALT);
    e.cnt = m_cnt;
    exp_q.push_back(e);
  endtask

  task automatic plain();
    step(0, 0, 0, 0, 16'h0, 0, 32'h0, 0, 32'h0);
  endtask

  task automatic go(input logic [31:0] a);
    step(0, 0, 0, 0, 16'h0, 0, 32'h0, 1, a);
  endtask

  initial begin
    int wait_cycles;
    // Reset, then free-run
    step(1, 0, 0, 0, 16'h0, 0, 32'h0, 0, 32'h0);
    repeat (4) plain();
    // Backward then forward branch
    go(32'd10);
    step(0, 0, 0, 1, 16'hFFFB, 0, 32'h0, 0, 32'h0);
    step(0, 0, 0, 1, 16'h0003, 0, 32'h0, 0, 32'h0);
    // Priority: jump over branch, jump_reg over jump
    go(32'd5);
    step(0, 0, 0, 1, 16'h0010, 1, 32'h40, 0, 32'h0);
    step(0, 0, 0, 0, 16'h0, 1, 32'h99, 1, 32'h7);
    // Stall with jump asserted, then release
    go(32'd20);
    repeat (3) step(0, 1, 0, 0, 16'h0, 1, 32'h123, 0, 32'h0);
    plain();
    plain();
    // Halt, ignore everything, then reset
    go(32'd30);
    step(0, 0, 1, 0, 16'h0, 0, 32'h0, 0, 32'h0);
    repeat (10) step(0, 1'($urandom), 1'($urandom), 1, 16'($urandom), 1, $urandom, 1'($urandom), $urandom);
    step(1, 0, 0, 0, 16'h0, 0, 32'h0, 0, 32'h0);
    // PC wrap and reset mid-stall
    go(32'hFFFF_FFFF);
    plain();
    plain();
    step(0, 1, 0, 0, 16'h0, 0, 32'h0, 0, 32'h0);
    step(1, 1, 0, 0, 16'h0, 0, 32'h0, 0, 32'h0);
    // Random traffic
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 99) < 2), ($urandom_range(0, 99) < 20),
           ($urandom_range(0, 99) < 3), 1'($urandom), 16'($urandom),
           ($urandom_range(0, 99) < 25), $urandom,
           ($urandom_range(0, 99) < 15), $urandom);
    end
    @(negedge clk);
    reset = 0; stall = 0; halt = 0; branch_taken = 0; jump = 0; jump_reg = 0;
    wait_cycles = 0;
    while (exp_q.size() > 0 && wait_cycles < 10) begin
      @(negedge clk);
      wait_cycles++;
    end
    if (exp_q.size() > 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
